// File: rtl/tbox_move_ctrl.sv
// tbox_move_ctrl: player-input front end for the TBox board.
// Debounces five push buttons, moves a wrapping 3x3 cursor and issues a
// timed set/row/col strobe into TBox. It then uses TBox's occupancy to
// decide whether the move landed. All outputs are registered.
module tbox_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SET_CYCLES      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_place,
  input  logic [8:0] valid,
  input  logic [1:0] game_state,
  output logic       set,
  output logic [1:0] row,
  output logic [1:0] col,
  output logic [1:0] cur_row,
  output logic [1:0] cur_col,
  output logic       x_turn,
  output logic [3:0] move_count,
  output logic       accepted,
  output logic       rejected
);

  // Both counters only need to reach (limit - 1) before they wrap back to zero.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SET_CYCLES > 1) ? $clog2(SET_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_CHECK = 2'b10
  } state_t;

  // Board cell index for 1-based row/col encodings; the result is 0..8.
  function automatic logic [3:0] cell_idx(input logic [1:0] r, input logic [1:0] c);
    return ({2'b00, r} - 4'd1) * 4'd3 + ({2'b00, c} - 4'd1);
  endfunction

  // Bit order: 0 place, 1 up, 2 down, 3 left, 4 right. A lower bit has higher priority.
  logic [4:0]    raw_s;
  logic [4:0]    db_r;
  logic [4:0]    db_prev_r;
  logic [4:0]    press_s;
  logic [CW-1:0] db_cnt_r [5];

  state_t        state_r;
  state_t        state_next_s;
  logic [SW-1:0] issue_cnt_r;
  logic          place_blocked_s;

  logic          set_s;
  logic [1:0]    row_s;
  logic [1:0]    col_s;
  logic [1:0]    cur_row_s;
  logic [1:0]    cur_col_s;
  logic          x_turn_s;
  logic [3:0]    move_count_s;
  logic          accepted_s;
  logic          rejected_s;

  assign raw_s   = {btn_right, btn_left, btn_down, btn_up, btn_place};
  assign press_s = db_r & ~db_prev_r;

  // A place request is refused up front if the game is over or the cursor cell is taken.
  assign place_blocked_s = (game_state != 2'b00) || valid[cell_idx(cur_row, cur_col)];

  // Per-button debounce: the level flips only after holding a new value long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_r      <= 5'b00000;
      db_prev_r <= 5'b00000;
      for (int i = 0; i < 5; i++) begin
        db_cnt_r[i] <= {CW{1'b0}};
      end
    end else begin
      db_prev_r <= db_r;
      for (int i = 0; i < 5; i++) begin
        if (raw_s[i] != db_r[i]) begin
          if (db_cnt_r[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_r[i]     <= raw_s[i];
            db_cnt_r[i] <= {CW{1'b0}};
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + CW'(1);
          end
        end else begin
          db_cnt_r[i] <= {CW{1'b0}};
        end
      end
    end
  end

  // State register, set-phase counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      issue_cnt_r <= {SW{1'b0}};
      set         <= 1'b0;
      row         <= 2'b01;
      col         <= 2'b01;
      cur_row     <= 2'b01;
      cur_col     <= 2'b01;
      x_turn      <= 1'b1;
      move_count  <= 4'd0;
      accepted    <= 1'b0;
      rejected    <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      issue_cnt_r <= (state_r == ST_ISSUE) ? issue_cnt_r + SW'(1) : {SW{1'b0}};
      set         <= set_s;
      row         <= row_s;
      col         <= col_s;
      cur_row     <= cur_row_s;
      cur_col     <= cur_col_s;
      x_turn      <= x_turn_s;
      move_count  <= move_count_s;
      accepted    <= accepted_s;
      rejected    <= rejected_s;
    end
  end

  // Next-state logic: an unblocked place starts ISSUE, which lasts SET_CYCLES cycles, then one CHECK cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (press_s[0] && !place_blocked_s) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (issue_cnt_r == SW'(SET_CYCLES - 1)) begin
          state_next_s = ST_CHECK;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_CHECK: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Output next values: cursor moves and place decisions in IDLE, move outcome in CHECK.
  always_comb begin
    set_s        = (state_next_s == ST_ISSUE);
    row_s        = row;
    col_s        = col;
    cur_row_s    = cur_row;
    cur_col_s    = cur_col;
    x_turn_s     = x_turn;
    move_count_s = move_count;
    accepted_s   = 1'b0;
    rejected_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (press_s[0]) begin
          if (place_blocked_s) begin
            rejected_s = 1'b1;
          end else begin
            row_s = cur_row;
            col_s = cur_col;
          end
        end else if (press_s[1]) begin
          cur_row_s = (cur_row == 2'b01) ? 2'b11 : cur_row - 2'b01;
        end else if (press_s[2]) begin
          cur_row_s = (cur_row == 2'b11) ? 2'b01 : cur_row + 2'b01;
        end else if (press_s[3]) begin
          cur_col_s = (cur_col == 2'b01) ? 2'b11 : cur_col - 2'b01;
        end else if (press_s[4]) begin
          cur_col_s = (cur_col == 2'b11) ? 2'b01 : cur_col + 2'b01;
        end else begin
          cur_row_s = cur_row;
        end
      end
      ST_ISSUE: begin
        row_s = row;
        col_s = col;
      end
      ST_CHECK: begin
        if (valid[cell_idx(row, col)]) begin
          accepted_s   = 1'b1;
          move_count_s = (move_count < 4'd9) ? move_count + 4'd1 : move_count;
          x_turn_s     = ~x_turn;
        end else begin
          rejected_s = 1'b1;
        end
      end
      default: begin
        accepted_s = 1'b0;
        rejected_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_tbox_move_ctrl.sv
// Testbench for tbox_move_ctrl. It drives directed button vectors against a
// small behavioural TBox model and checks results against hand-computed
// expectations.
module tb_tbox_move_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_mask;   // {right, left, down, up, place}
  logic [8:0] valid;
  logic [1:0] game_state;
  logic       set;
  logic [1:0] row, col, cur_row, cur_col;
  logic       x_turn;
  logic [3:0] move_count;
  logic       accepted, rejected;

  int tests = 0;
  int fails = 0;

  // TBox model state
  logic [8:0] board_x, board_o;
  logic       tb_xturn;
  logic       gs_force;

  typedef struct packed {
    logic [4:0] mask;
    logic [1:0] er;
    logic [1:0] ec;
  } cur_vec_t;

  typedef struct packed {
    logic [1:0] tr;
    logic [1:0] tc;
  } move_vec_t;

  cur_vec_t  cvec [9];
  move_vec_t mvec [6];

  tbox_move_ctrl #(.DEBOUNCE_CYCLES(4), .SET_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_up     (btn_mask[1]),
    .btn_down   (btn_mask[2]),
    .btn_left   (btn_mask[3]),
    .btn_right  (btn_mask[4]),
    .btn_place  (btn_mask[0]),
    .valid      (valid),
    .game_state (game_state),
    .set        (set),
    .row        (row),
    .col        (col),
    .cur_row    (cur_row),
    .cur_col    (cur_col),
    .x_turn     (x_turn),
    .move_count (move_count),
    .accepted   (accepted),
    .rejected   (rejected)
  );

  always #5 clk = ~clk;

  function automatic logic has_line(input logic [8:0] b);
    return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  assign valid      = board_x | board_o;
  assign game_state = gs_force               ? 2'b10 :
                      has_line(board_x)      ? 2'b01 :
                      has_line(board_o)      ? 2'b10 :
                      (&(board_x | board_o)) ? 2'b11 : 2'b00;

  // One clock cycle; the TBox model writes the cell that set/row/col presented at that edge.
  task automatic tick();
    logic       s;
    logic [1:0] r, c;
    int         i;
    s = set;
    r = row;
    c = col;
    @(posedge clk);
    #1;
    if (s && r != 2'b00 && c != 2'b00) begin
      i = (int'(r) - 1) * 3 + (int'(c) - 1);
      if (!board_x[i] && !board_o[i]) begin
        if (tb_xturn) board_x[i] = 1'b1;
        else          board_o[i] = 1'b1;
        tb_xturn = ~tb_xturn;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic press_mask(input logic [4:0] m);
    btn_mask = m;
    repeat (6) tick();
    btn_mask = 5'b00000;
    repeat (6) tick();
  endtask

  task automatic check_reset(input string name);
    chk({name, ".set"},        int'(set),        0);
    chk({name, ".row"},        int'(row),        1);
    chk({name, ".col"},        int'(col),        1);
    chk({name, ".cur_row"},    int'(cur_row),    1);
    chk({name, ".cur_col"},    int'(cur_col),    1);
    chk({name, ".x_turn"},     int'(x_turn),     1);
    chk({name, ".move_count"}, int'(move_count), 0);
    chk({name, ".accepted"},   int'(accepted),   0);
    chk({name, ".rejected"},   int'(rejected),   0);
  endtask

  // Press place and watch the whole transaction for 20 cycles.
  // The debounced edge forms after the 4th edge, so set or an immediate
  // rejection first shows up after tick 5.
  task automatic check_place(input string name, input int exp_set, input int exp_acc,
                             input int exp_rej, input logic [1:0] er, input logic [1:0] ec);
    int n_set, n_acc, n_rej, both, first_set, first_res, rc_bad;
    n_set = 0; n_acc = 0; n_rej = 0; both = 0; rc_bad = 0;
    first_set = -1; first_res = -1;
    btn_mask = 5'b00001;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 6) btn_mask = 5'b00000;
      if (set) begin
        n_set++;
        if (first_set < 0) first_set = k;
      end
      if (first_set > 0 && k <= first_set + 2 && (row != er || col != ec)) rc_bad++;
      if (accepted) begin
        n_acc++;
        if (first_res < 0) first_res = k;
      end
      if (rejected) begin
        n_rej++;
        if (first_res < 0) first_res = k;
      end
      if (accepted && rejected) both++;
    end
    chk({name, ".set_cycles"}, n_set, exp_set);
    chk({name, ".accepted"},   n_acc, exp_acc);
    chk({name, ".rejected"},   n_rej, exp_rej);
    chk({name, ".acc_and_rej"}, both, 0);
    if (exp_set > 0) begin
      chk({name, ".set_latency"},    first_set, 5);
      chk({name, ".result_latency"}, first_res - first_set, 3);
      chk({name, ".rowcol_bad"},     rc_bad, 0);
    end else begin
      chk({name, ".reject_latency"}, first_res, 5);
    end
  endtask

  initial begin
    int         changes;
    logic [1:0] prev_row, exp_r, exp_c;
    logic       seen;

    cvec[0] = '{5'b00100, 2'b11, 2'b01};  // down
    cvec[1] = '{5'b00100, 2'b01, 2'b01};  // down wraps
    cvec[2] = '{5'b00010, 2'b11, 2'b01};  // up wraps
    cvec[3] = '{5'b00010, 2'b10, 2'b01};  // up
    cvec[4] = '{5'b01000, 2'b10, 2'b11};  // left wraps
    cvec[5] = '{5'b10000, 2'b10, 2'b01};  // right wraps
    cvec[6] = '{5'b10100, 2'b11, 2'b01};  // down+right together: down wins
    cvec[7] = '{5'b00010, 2'b10, 2'b01};  // up
    cvec[8] = '{5'b10000, 2'b10, 2'b10};  // right

    mvec[0] = '{2'b01, 2'b01};
    mvec[1] = '{2'b10, 2'b10};
    mvec[2] = '{2'b01, 2'b11};
    mvec[3] = '{2'b01, 2'b10};
    mvec[4] = '{2'b11, 2'b11};
    mvec[5] = '{2'b11, 2'b10};

    reset    = 1'b1;
    btn_mask = 5'b00000;
    board_x  = 9'b0;
    board_o  = 9'b0;
    tb_xturn = 1'b1;
    gs_force = 1'b0;
    repeat (2) tick();
    check_reset("reset");
    reset = 1'b0;
    tick();

    // Short glitch on down: never debounced.
    btn_mask = 5'b00100;
    repeat (3) tick();
    btn_mask = 5'b00000;
    repeat (8) tick();
    chk("glitch.cur_row", int'(cur_row), 1);

    // Long hold on down: exactly one step.
    changes  = 0;
    prev_row = cur_row;
    btn_mask = 5'b00100;
    for (int k = 0; k < 14; k++) begin
      if (k == 6) btn_mask = 5'b00000;
      tick();
      if (cur_row != prev_row) changes++;
      prev_row = cur_row;
    end
    chk("hold.changes", changes, 1);
    chk("hold.cur_row", int'(cur_row), 2);

    for (int i = 0; i < 9; i++) begin
      press_mask(cvec[i].mask);
      chk($sformatf("cursor%0d.row", i), int'(cur_row), int'(cvec[i].er));
      chk($sformatf("cursor%0d.col", i), int'(cur_col), int'(cvec[i].ec));
    end

    // Empty centre cell.
    check_place("place_empty", 2, 1, 0, 2'b10, 2'b10);
    chk("place_empty.move_count", int'(move_count), 1);
    chk("place_empty.x_turn",     int'(x_turn),     0);

    // Occupied corner.
    press_mask(5'b00010);
    press_mask(5'b01000);
    chk("occ.cur_row", int'(cur_row), 1);
    chk("occ.cur_col", int'(cur_col), 1);
    board_x[0] = 1'b1;
    check_place("occupied", 0, 0, 1, 2'b01, 2'b01);
    chk("occupied.move_count", int'(move_count), 1);
    chk("occupied.x_turn",     int'(x_turn),     0);

    // Game over, empty cell (01,10).
    press_mask(5'b10000);
    gs_force = 1'b1;
    check_place("game_over", 0, 0, 1, 2'b01, 2'b10);
    chk("game_over.move_count", int'(move_count), 1);
    gs_force = 1'b0;

    // Full game against the TBox model: O wins on the middle column.
    reset    = 1'b1;
    board_x  = 9'b0;
    board_o  = 9'b0;
    tb_xturn = 1'b1;
    repeat (2) tick();
    check_reset("reset2");
    reset = 1'b0;
    tick();
    exp_r = 2'b01;
    exp_c = 2'b01;
    for (int m = 0; m < 6; m++) begin
      for (int n = 0; n < 3 && exp_r != mvec[m].tr; n++) begin
        press_mask(5'b00100);
        exp_r = (exp_r == 2'b11) ? 2'b01 : exp_r + 2'b01;
      end
      for (int n = 0; n < 3 && exp_c != mvec[m].tc; n++) begin
        press_mask(5'b10000);
        exp_c = (exp_c == 2'b11) ? 2'b01 : exp_c + 2'b01;
      end
      chk($sformatf("game%0d.cur_row", m), int'(cur_row), int'(mvec[m].tr));
      chk($sformatf("game%0d.cur_col", m), int'(cur_col), int'(mvec[m].tc));
      check_place($sformatf("game%0d", m), 2, 1, 0, mvec[m].tr, mvec[m].tc);
      chk($sformatf("game%0d.move_count", m), int'(move_count), m + 1);
      chk($sformatf("game%0d.x_turn", m), int'(x_turn), (m % 2 == 1) ? 1 : 0);
    end
    check_place("seventh", 0, 0, 1, 2'b11, 2'b10);
    chk("seventh.move_count", int'(move_count), 6);

    // Reset in the middle of ISSUE.
    board_x  = 9'b0;
    board_o  = 9'b0;
    tb_xturn = 1'b1;
    seen     = 1'b0;
    btn_mask = 5'b00001;
    for (int k = 0; k < 12 && !seen; k++) begin
      tick();
      if (set) seen = 1'b1;
    end
    chk("mid_issue.set_seen", int'(seen), 1);
    reset    = 1'b1;
    btn_mask = 5'b00000;
    tick();
    check_reset("mid_issue");
    reset = 1'b0;
    repeat (4) tick();
    chk("mid_issue.set_after", int'(set), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tbox_move_ctrl.md
Name: tbox_move_ctrl

Overview:
- Upstream player-input stage for the TBox board.
- Turns raw push-button levels (four cursor directions plus place) into a cursor position and a timed set/row/col move strobe into TBox.
- Uses TBox's valid and game_state outputs to reject moves onto occupied cells and moves after the game is over.
- Tracks move count and whose turn it is (X moves first).

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a button input must hold a new level before the debounced level changes.
- SET_CYCLES, 2: number of clk cycles set is held high per move.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- btn_up  input  1  raw level; moves cursor row toward 2'b01
- btn_down  input  1  raw level; moves cursor row toward 2'b11
- btn_left  input  1  raw level; moves cursor col toward 2'b01
- btn_right  input  1  raw level; moves cursor col toward 2'b11
- btn_place  input  1  raw level; requests a move at the cursor
- valid  input  9  TBox occupancy, bit index = (row-1)*3 + (col-1)
- game_state  input  2  TBox state: 00 game on, 01 X won, 10 O won, 11 draw
- set  output  1  move strobe to TBox
- row  output  2  row to TBox, encoding 01..11 (00 never driven while set=1)
- col  output  2  col to TBox, encoding 01..11
- cur_row  output  2  cursor row, 01..11
- cur_col  output  2  cursor col, 01..11
- x_turn  output  1  1 when next move is X
- move_count  output  4  accepted moves since reset, 0..9
- accepted  output  1  one-cycle pulse: move landed on the board
- rejected  output  1  one-cycle pulse: place request refused or not taken

Behaviour:
- Reset (synchronous, active-high), applied in the next rising-edge cycle:
  - set=0; row=01; col=01; cur_row=01; cur_col=01; x_turn=1; move_count=0; accepted=0; rejected=0.
  - Debounce counters cleared; debounced levels = 0; FSM = IDLE.
  - Reset has priority over everything, including in the middle of ISSUE or CHECK.
- Debounce:
  - Each button has its own counter.
  - When the raw level differs from the debounced level, the counter increments each cycle; otherwise it clears.
  - On reaching DEBOUNCE_CYCLES the debounced level flips and the counter clears.
  - A press event is a single-cycle 0->1 edge of the debounced level.
- Event arbitration:
  - Only one press event acts per cycle, priority place > up > down > left > right; lower-priority events in that cycle are discarded.
  - All events are discarded while the FSM is not IDLE.
- Cursor movement (IDLE only):
  - up: cur_row decrements, 01 wraps to 11.
  - down: cur_row increments, 11 wraps to 01.
  - left/right: same rules applied to cur_col.
  - Cursor updates on the cycle after the event.
- FSM states: IDLE, ISSUE, CHECK.
  - IDLE, place event:
    - If game_state != 00, or valid[idx(cur_row,cur_col)] = 1: pulse rejected the next cycle and stay in IDLE.
    - Otherwise latch row/col from the cursor and go to ISSUE.
  - ISSUE:
    - set=1 for exactly SET_CYCLES cycles.
    - row/col are held stable for the entire ISSUE and CHECK period.
    - Then go to CHECK with set=0.
  - CHECK (one cycle):
    - If valid[idx(row,col)] = 1: pulse accepted, increment move_count (saturating at 9), toggle x_turn.
    - Otherwise pulse rejected.
    - Return to IDLE.
- Latency:
  - Place edge to first set=1: 1 cycle.
  - Place edge to accepted/rejected: SET_CYCLES+2 cycles.
- Constraints:
  - set is never high in IDLE or CHECK.
  - accepted and rejected are never high together.
  - If game_state becomes non-00 during ISSUE, the move still completes; the outcome is judged only on valid.
- Width rule: idx = (row-1)*3 + (col-1), computed in 4 bits; range 0..8.

Test Plan:
- Reset:
  - Hold reset 2 cycles.
  - Required: cur_row=01, cur_col=01, set=0, move_count=0, x_turn=1.
- Debounce:
  - Pulse btn_down high for 3 cycles: cursor unchanged.
  - Hold btn_down for 6 cycles: cur_row=10 exactly once.
  - Press down 2 more times: cur_row wraps 11 -> 01.
- Place on empty cell:
  - Cursor (10,10), valid=0, game_state=00, press place.
  - Required: set=1 for 2 cycles with row=10, col=10.
  - Model valid[4]=1, then check accepted pulse, move_count=1, x_turn=0.
- Occupied cell:
  - valid[0]=1, cursor (01,01), press place.
  - Required: set stays 0, rejected pulses once, move_count unchanged.
- Game over:
  - game_state=10, cursor on an empty cell, press place.
  - Required: no set, rejected pulse.
- Full game with TBox attached:
  - Drive moves (01,01),(10,10),(01,11),(01,10),(11,11),(11,10).
  - Required: six accepted pulses, game_state=10, move_count=6.
  - A seventh place request yields rejected.
  - Assert reset mid-ISSUE: set drops the next cycle and all outputs return to reset values.
